// File: rtl/axi_scratch_responder.sv
// AXI4 slave that answers the Rocket memory port from on-chip block RAM.
// Independent write and read engines, each with one transaction in flight.
module axi_scratch_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                ID_W       = 6,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_axi_aw_valid,
    output logic                io_axi_aw_ready,
    input  logic [ADDR_W-1:0]   io_axi_aw_bits_addr,
    input  logic [ID_W-1:0]     io_axi_aw_bits_id,
    input  logic [7:0]          io_axi_aw_bits_len,
    input  logic [2:0]          io_axi_aw_bits_size,
    input  logic [1:0]          io_axi_aw_bits_burst,
    input  logic                io_axi_w_valid,
    output logic                io_axi_w_ready,
    input  logic [DATA_W-1:0]   io_axi_w_bits_data,
    input  logic [DATA_W/8-1:0] io_axi_w_bits_strb,
    input  logic                io_axi_w_bits_last,
    output logic                io_axi_b_valid,
    input  logic                io_axi_b_ready,
    output logic [ID_W-1:0]     io_axi_b_bits_id,
    output logic [1:0]          io_axi_b_bits_resp,
    input  logic                io_axi_ar_valid,
    output logic                io_axi_ar_ready,
    input  logic [ADDR_W-1:0]   io_axi_ar_bits_addr,
    input  logic [ID_W-1:0]     io_axi_ar_bits_id,
    input  logic [7:0]          io_axi_ar_bits_len,
    input  logic [2:0]          io_axi_ar_bits_size,
    input  logic [1:0]          io_axi_ar_bits_burst,
    output logic                io_axi_r_valid,
    input  logic                io_axi_r_ready,
    output logic [ID_W-1:0]     io_axi_r_bits_id,
    output logic [DATA_W-1:0]   io_axi_r_bits_data,
    output logic [1:0]          io_axi_r_bits_resp,
    output logic                io_axi_r_bits_last
);

    localparam int                DEPTH  = 1 << DEPTH_LOG2;
    localparam int                STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(64'd8 << DEPTH_LOG2);
    localparam logic [1:0]        OKAY   = 2'b00;
    localparam logic [1:0]        SLVERR = 2'b10;
    localparam logic [1:0]        DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

    // Unsigned offset compare also rejects addresses below the base.
    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
    endfunction

    wState_t           wState_q, wState_d;
    logic [ADDR_W-1:0] wAddr_q, wAddr_d;
    logic [ID_W-1:0]   wId_q, wId_d;
    logic [7:0]        wLen_q, wLen_d, wBeat_q, wBeat_d;
    logic [2:0]        wSize_q, wSize_d;
    logic [1:0]        wBurst_q, wBurst_d, bResp_q, bResp_d;
    logic              wDec_q, wDec_d, wSlv_q, wSlv_d;
    logic              wBeatInRange, wIsLast, wLastBad, memWe;

    rState_t           rState_q, rState_d;
    logic [ADDR_W-1:0] rAddr_q, rAddr_d;
    logic [ID_W-1:0]   rId_q, rId_d;
    logic [7:0]        rLen_q, rLen_d, rBeat_q, rBeat_d;
    logic [2:0]        rSize_q, rSize_d;
    logic [1:0]        rBurst_q, rBurst_d, rResp_q, rResp_d;
    logic              rLast_q, rLast_d, rdEn;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     ramRdata_q;
    logic [DEPTH_LOG2-1:0] wIdx, rIdx;

    assign wIdx         = wAddr_q[DEPTH_LOG2+2:3];
    assign rIdx         = rAddr_q[DEPTH_LOG2+2:3];
    assign wBeatInRange = inRange(wAddr_q);
    assign wIsLast      = (wBeat_q == wLen_q);
    assign wLastBad     = (io_axi_w_bits_last != wIsLast);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wState_q <= W_IDLE;
            wAddr_q  <= '0;
            wId_q    <= '0;
            wLen_q   <= '0;
            wBeat_q  <= '0;
            wSize_q  <= '0;
            wBurst_q <= '0;
            bResp_q  <= OKAY;
            wDec_q   <= 1'b0;
            wSlv_q   <= 1'b0;
        end else begin
            wState_q <= wState_d;
            wAddr_q  <= wAddr_d;
            wId_q    <= wId_d;
            wLen_q   <= wLen_d;
            wBeat_q  <= wBeat_d;
            wSize_q  <= wSize_d;
            wBurst_q <= wBurst_d;
            bResp_q  <= bResp_d;
            wDec_q   <= wDec_d;
            wSlv_q   <= wSlv_d;
        end
    end

    // The burst always takes len+1 beats; a misplaced w_last only taints the response.
    always_comb begin
        wState_d = wState_q;
        wAddr_d  = wAddr_q;
        wId_d    = wId_q;
        wLen_d   = wLen_q;
        wBeat_d  = wBeat_q;
        wSize_d  = wSize_q;
        wBurst_d = wBurst_q;
        bResp_d  = bResp_q;
        wDec_d   = wDec_q;
        wSlv_d   = wSlv_q;
        memWe    = 1'b0;
        case (wState_q)
            W_IDLE: if (io_axi_aw_valid) begin
                wAddr_d  = io_axi_aw_bits_addr;
                wId_d    = io_axi_aw_bits_id;
                wLen_d   = io_axi_aw_bits_len;
                wSize_d  = io_axi_aw_bits_size;
                wBurst_d = io_axi_aw_bits_burst;
                wBeat_d  = '0;
                wDec_d   = 1'b0;
                wSlv_d   = io_axi_aw_bits_burst[1];
                wState_d = W_DATA;
            end
            W_DATA: if (io_axi_w_valid) begin
                memWe   = wBeatInRange && !wBurst_q[1];
                wAddr_d = nextAddr(wAddr_q, wSize_q, wBurst_q);
                wBeat_d = wBeat_q + 8'd1;
                wDec_d  = wDec_q || !wBeatInRange;
                wSlv_d  = wSlv_q || wLastBad;
                if (wIsLast) begin
                    bResp_d  = wDec_d ? DECERR : (wSlv_d ? SLVERR : OKAY);
                    wState_d = W_RESP;
                end
            end
            W_RESP: if (io_axi_b_ready) wState_d = W_IDLE;
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rState_q <= R_IDLE;
            rAddr_q  <= '0;
            rId_q    <= '0;
            rLen_q   <= '0;
            rBeat_q  <= '0;
            rSize_q  <= '0;
            rBurst_q <= '0;
            rResp_q  <= OKAY;
            rLast_q  <= 1'b0;
        end else begin
            rState_q <= rState_d;
            rAddr_q  <= rAddr_d;
            rId_q    <= rId_d;
            rLen_q   <= rLen_d;
            rBeat_q  <= rBeat_d;
            rSize_q  <= rSize_d;
            rBurst_q <= rBurst_d;
            rResp_q  <= rResp_d;
            rLast_q  <= rLast_d;
        end
    end

    always_comb begin
        rState_d = rState_q;
        rAddr_d  = rAddr_q;
        rId_d    = rId_q;
        rLen_d   = rLen_q;
        rBeat_d  = rBeat_q;
        rSize_d  = rSize_q;
        rBurst_d = rBurst_q;
        rResp_d  = rResp_q;
        rLast_d  = rLast_q;
        rdEn     = 1'b0;
        case (rState_q)
            R_IDLE: if (io_axi_ar_valid) begin
                rAddr_d  = io_axi_ar_bits_addr;
                rId_d    = io_axi_ar_bits_id;
                rLen_d   = io_axi_ar_bits_len;
                rSize_d  = io_axi_ar_bits_size;
                rBurst_d = io_axi_ar_bits_burst;
                rBeat_d  = '0;
                rState_d = R_FETCH;
            end
            R_FETCH: begin
                rdEn     = 1'b1;
                rResp_d  = !inRange(rAddr_q) ? DECERR : (rBurst_q[1] ? SLVERR : OKAY);
                rLast_d  = (rBeat_q == rLen_q);
                rState_d = R_DATA;
            end
            R_DATA: if (io_axi_r_ready) begin
                if (rLast_q) begin
                    rState_d = R_IDLE;
                end else begin
                    rAddr_d  = nextAddr(rAddr_q, rSize_q, rBurst_q);
                    rBeat_d  = rBeat_q + 8'd1;
                    rState_d = R_FETCH;
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    // Read data register only loads on fetch, so it holds steady through R_DATA stalls.
    always_ff @(posedge clock) begin
        if (memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (io_axi_w_bits_strb[b]) mem[wIdx][b*8 +: 8] <= io_axi_w_bits_data[b*8 +: 8];
            end
        end
        if (rdEn) ramRdata_q <= mem[rIdx];
    end

    assign io_axi_aw_ready    = (wState_q == W_IDLE);
    assign io_axi_w_ready     = (wState_q == W_DATA);
    assign io_axi_b_valid     = (wState_q == W_RESP);
    assign io_axi_b_bits_id   = wId_q;
    assign io_axi_b_bits_resp = bResp_q;
    assign io_axi_ar_ready    = (rState_q == R_IDLE);
    assign io_axi_r_valid     = (rState_q == R_DATA);
    assign io_axi_r_bits_id   = rId_q;
    assign io_axi_r_bits_resp = rResp_q;
    assign io_axi_r_bits_last = (rState_q == R_DATA) && rLast_q;
    assign io_axi_r_bits_data = ((rState_q == R_DATA) && (rResp_q == OKAY)) ? ramRdata_q : '0;

endmodule

// File: tb/tb_axi_scratch_responder.sv
// Bench for axi_scratch_responder: transaction-level memory model plus a
// per-cycle monitor comparing every B and R beat against expected queues.
module tb_axi_scratch_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clock, reset;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0] aw_addr, ar_addr;
    logic [5:0]  aw_id, ar_id, b_id, r_id;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [63:0] w_data, r_data;

    axi_scratch_responder dut (
        .clock(clock), .reset(reset),
        .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
        .io_axi_aw_bits_addr(aw_addr), .io_axi_aw_bits_id(aw_id),
        .io_axi_aw_bits_len(aw_len), .io_axi_aw_bits_size(aw_size),
        .io_axi_aw_bits_burst(aw_burst),
        .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
        .io_axi_w_bits_data(w_data), .io_axi_w_bits_strb(w_strb),
        .io_axi_w_bits_last(w_last),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready),
        .io_axi_b_bits_id(b_id), .io_axi_b_bits_resp(b_resp),
        .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
        .io_axi_ar_bits_addr(ar_addr), .io_axi_ar_bits_id(ar_id),
        .io_axi_ar_bits_len(ar_len), .io_axi_ar_bits_size(ar_size),
        .io_axi_ar_bits_burst(ar_burst),
        .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
        .io_axi_r_bits_id(r_id), .io_axi_r_bits_data(r_data),
        .io_axi_r_bits_resp(r_resp), .io_axi_r_bits_last(r_last)
    );

    typedef struct { logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; bit checkData; } rBeat_t;
    typedef struct { logic [5:0] id; logic [1:0] resp; } bRsp_t;

    int          passCount = 0, checkCount = 0, cyc = 0, arSeenCyc = 0;
    int          rMode = 0, bMode = 0;
    bit          firstPending = 0;
    logic [63:0] model [WORDS];
    bit          known [WORDS];
    logic [63:0] wData [256];
    logic [7:0]  wStrb [256];
    rBeat_t      rExp [$];
    bRsp_t       bExp [$];
    logic [63:0] rGotData [$];
    logic [1:0]  rGotResp [$];
    logic        rGotLast [$];
    logic [1:0]  bGotResp;
    logic [5:0]  bGotId;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Ready generators: 0 always ready, 1 toggling, 2 random, 3 never.
    always @(posedge clock) begin
        #1;
        case (rMode)
            0: r_ready = 1'b1;
            1: r_ready = ~r_ready;
            2: r_ready = 1'($urandom % 2);
            default: r_ready = 1'b0;
        endcase
        b_ready = (bMode == 0) ? 1'b1 : 1'($urandom % 2);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic failNow(input string name, input string msg);
        checkCount++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    function automatic logic [31:0] beatAddr(input logic [31:0] a, input int n, input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + 32'(n) * (32'd1 << size);
    endfunction

    function automatic bit beatInRange(input logic [31:0] a);
        return (a - BASE) < 32'(8 * WORDS);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'(a[14:3]);
    endfunction

    function automatic logic [63:0] gotData(input int k);
        return (k < rGotData.size()) ? rGotData[k] : 64'hx;
    endfunction

    function automatic logic [1:0] gotResp(input int k);
        return (k < rGotResp.size()) ? rGotResp[k] : 2'bxx;
    endfunction

    function automatic logic [63:0] initPattern(input int i);
        return {16'h0DD0, 16'(i), 32'hCAFE0000 | 32'(i)};
    endfunction

    // Compares every cycle a response is presented, so stalled beats are re-checked.
    always @(negedge clock) begin
        if (!reset) begin
            if (r_valid) begin
                if (firstPending) begin
                    checkOutput("r_first_latency", 64'(cyc - arSeenCyc), 64'd2);
                    firstPending = 0;
                end
                if (rExp.size() == 0) failNow("r_unexpected", "r_valid with no read outstanding");
                else begin
                    checkOutput("r_id", r_id, rExp[0].id);
                    checkOutput("r_resp", r_resp, rExp[0].resp);
                    checkOutput("r_last", r_last, rExp[0].last);
                    if (rExp[0].checkData) checkOutput("r_data", r_data, rExp[0].data);
                    if (r_ready) begin
                        rGotData.push_back(r_data);
                        rGotResp.push_back(r_resp);
                        rGotLast.push_back(r_last);
                        void'(rExp.pop_front());
                    end
                end
            end
            if (b_valid) begin
                if (bExp.size() == 0) failNow("b_unexpected", "b_valid with no write outstanding");
                else begin
                    checkOutput("b_id", b_id, bExp[0].id);
                    checkOutput("b_resp", b_resp, bExp[0].resp);
                    if (b_ready) begin
                        bGotResp = b_resp;
                        bGotId   = b_id;
                        void'(bExp.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyReset();
        aw_valid = 0; w_valid = 0; w_last = 0; ar_valid = 0;
        reset = 1;
        #3;
        checkOutput("rst_aw_ready", aw_ready, 1'b1);
        checkOutput("rst_ar_ready", ar_ready, 1'b1);
        checkOutput("rst_w_ready", w_ready, 1'b0);
        checkOutput("rst_b_valid", b_valid, 1'b0);
        checkOutput("rst_r_valid", r_valid, 1'b0);
        checkOutput("rst_r_last", r_last, 1'b0);
        checkOutput("rst_b_resp", b_resp, 2'b00);
        checkOutput("rst_r_resp", r_resp, 2'b00);
        checkOutput("rst_b_id", b_id, 6'd0);
        checkOutput("rst_r_id", r_id, 6'd0);
        checkOutput("rst_r_data", r_data, 64'd0);
        rExp.delete(); bExp.delete(); firstPending = 0;
        @(posedge clock); #1 reset = 0;
        @(posedge clock); #1;
        checkOutput("post_rst_aw_ready", aw_ready, 1'b1);
        checkOutput("post_rst_ar_ready", ar_ready, 1'b1);
    endtask

    // lastFlip inverts w_last on that beat; abortAt resets before sending that beat.
    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [5:0] id, input int lastFlip, input int abortAt);
        bit          dec, slv, in;
        logic [31:0] a;
        int          n, w;
        bRsp_t       e;
        dec = 0; slv = burst[1]; bGotResp = 2'bxx; bGotId = 6'bx;
        @(posedge clock); #1;
        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1;
        n = 0;
        do begin @(negedge clock); n++; end while (!aw_ready && n < 50);
        if (!aw_ready) begin failNow("aw_timeout", "aw_ready never seen"); aw_valid = 0; return; end
        @(posedge clock); #1 aw_valid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abortAt) begin applyReset(); return; end
            repeat ($urandom % 2) begin @(posedge clock); #1; end
            a = beatAddr(addr, i, size, burst);
            in = beatInRange(a);
            w_data = wData[i]; w_strb = wStrb[i];
            w_last = (i == int'(len)) ^ (i == lastFlip);
            w_valid = 1;
            dec = dec || !in;
            if (i == lastFlip) slv = 1;
            n = 0;
            do begin @(negedge clock); n++; end while (!w_ready && n < 50);
            if (!w_ready) begin failNow("w_timeout", "w_ready never seen"); w_valid = 0; return; end
            if (in && !burst[1]) begin
                w = wordOf(a);
                if (lastFlip >= 0) known[w] = 0;
                else begin
                    for (int b = 0; b < 8; b++) if (wStrb[i][b]) model[w][b*8 +: 8] = wData[i][b*8 +: 8];
                    if (wStrb[i] == 8'hFF) known[w] = 1;
                end
            end
            if (i == int'(len)) begin
                e.id = id; e.resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
                bExp.push_back(e);
            end
            @(posedge clock); #1 w_valid = 0; w_last = 0;
        end
        n = 0;
        while (bExp.size() > 0 && n < 300) begin @(negedge clock); n++; end
        if (bExp.size() > 0) begin failNow("b_timeout", "write response never accepted"); bExp.delete(); end
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [5:0] id, input bit abortOnValid);
        rBeat_t      e;
        logic [31:0] a;
        int          n;
        rGotData.delete(); rGotResp.delete(); rGotLast.delete();
        for (int i = 0; i <= int'(len); i++) begin
            a = beatAddr(addr, i, size, burst);
            e.id = id;
            e.last = (i == int'(len));
            e.resp = !beatInRange(a) ? 2'b11 : (burst[1] ? 2'b10 : 2'b00);
            e.data = (e.resp == 2'b00) ? model[wordOf(a)] : 64'd0;
            e.checkData = (e.resp != 2'b00) || known[wordOf(a)];
            rExp.push_back(e);
        end
        @(posedge clock); #1;
        ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1;
        n = 0;
        do begin @(negedge clock); n++; end while (!ar_ready && n < 50);
        if (!ar_ready) begin failNow("ar_timeout", "ar_ready never seen"); ar_valid = 0; rExp.delete(); return; end
        arSeenCyc = cyc; firstPending = 1;
        @(posedge clock); #1 ar_valid = 0;
        if (abortOnValid) begin
            n = 0;
            while (!r_valid && n < 20) begin @(negedge clock); n++; end
            if (!r_valid) failNow("r_timeout", "r_valid never seen before abort");
            applyReset();
            return;
        end
        n = 0;
        while (rExp.size() > 0 && n < 4000) begin @(negedge clock); n++; end
        if (rExp.size() > 0) begin failNow("r_timeout", "read beats missing"); rExp.delete(); end
    endtask

    task automatic applyStimulus(input int iterations);
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          k;
        for (int it = 0; it < iterations; it++) begin
            rMode = $urandom % 3; bMode = $urandom % 2;
            size = ($urandom % 4 == 0) ? 3'($urandom % 3) : 3'd3;
            k = $urandom % 10;
            burst = (k < 6) ? 2'b01 : (k < 9) ? 2'b00 : 2'($urandom_range(2, 3));
            len = 8'($urandom % 8);
            k = $urandom % 10;
            if (k < 7)      addr = BASE + 32'($urandom % 56) * 8 + ((32'($urandom % 8) >> size) << size);
            else if (k < 9) addr = BASE + 32'(4088 + $urandom % 8) * 8;
            else            addr = BASE - 32'h100 + 32'($urandom % 16) * 8;
            if ($urandom % 2 == 0) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wData[i] = {$urandom, $urandom};
                    wStrb[i] = ($urandom % 2 == 0) ? 8'hFF : 8'($urandom);
                end
                writeBurst(addr, len, size, burst, 6'($urandom), -1, -1);
            end else begin
                readBurst(addr, len, size, burst, 6'($urandom), 0);
            end
        end
        rMode = 0; bMode = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clock = 0; reset = 0;
        aw_valid = 0; w_valid = 0; w_last = 0; ar_valid = 0; r_ready = 1; b_ready = 1;
        aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0; w_data = 0; w_strb = 0;
        ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        for (int i = 0; i < WORDS; i++) known[i] = 0;
        #2;
        applyReset();

        for (int i = 0; i < 64; i++) begin wData[i] = initPattern(i); wStrb[i] = 8'hFF; end
        writeBurst(BASE, 8'd63, 3'd3, 2'b01, 6'd1, -1, -1);
        for (int i = 0; i < 8; i++) begin wData[i] = initPattern(4088 + i); wStrb[i] = 8'hFF; end
        writeBurst(BASE + 32'h7FC0, 8'd7, 3'd3, 2'b01, 6'd2, -1, -1);

        wData[0] = 64'h1122334455667788; wStrb[0] = 8'hFF;
        writeBurst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 6'h2A, -1, -1);
        checkOutput("single_b_resp", bGotResp, 2'b00);
        checkOutput("single_b_id", bGotId, 6'h2A);
        readBurst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 6'h15, 0);
        checkOutput("single_r_data", gotData(0), 64'h1122334455667788);
        checkOutput("single_r_last", rGotLast.size() > 0 ? rGotLast[0] : 1'bx, 1'b1);

        for (int i = 0; i < 8; i++) begin wData[i] = 64'(i); wStrb[i] = 8'hFF; end
        writeBurst(BASE + 32'h100, 8'd7, 3'd3, 2'b01, 6'h03, -1, -1);
        rMode = 1;
        readBurst(BASE + 32'h100, 8'd7, 3'd3, 2'b01, 6'h04, 0);
        rMode = 0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("incr8_data", gotData(k), 64'(k));
            checkOutput("incr8_last", k < rGotLast.size() ? rGotLast[k] : 1'bx, 1'(k == 7));
        end

        wData[0] = 64'hFFFFFFFFFFFFFFFF; wStrb[0] = 8'hFF;
        writeBurst(BASE + 32'h1F0, 8'd0, 3'd3, 2'b01, 6'h05, -1, -1);
        wData[0] = 64'hAAAAAAAABBBBBBBB; wStrb[0] = 8'h0F;
        writeBurst(BASE + 32'h1F0, 8'd0, 3'd3, 2'b01, 6'h06, -1, -1);
        readBurst(BASE + 32'h1F0, 8'd0, 3'd3, 2'b01, 6'h07, 0);
        checkOutput("strobe_merge", gotData(0), 64'hFFFFFFFFBBBBBBBB);

        for (int i = 0; i < 4; i++) begin wData[i] = 64'(i + 1); wStrb[i] = 8'hFF; end
        writeBurst(BASE + 32'h1F8, 8'd3, 3'd3, 2'b00, 6'h08, -1, -1);
        readBurst(BASE + 32'h1F8, 8'd0, 3'd3, 2'b01, 6'h09, 0);
        checkOutput("fixed_last_wins", gotData(0), 64'd4);

        wData[0] = 64'hDEAD; wData[1] = 64'hBEEF; wStrb[0] = 8'hFF; wStrb[1] = 8'hFF;
        writeBurst(BASE - 32'h10, 8'd1, 3'd3, 2'b01, 6'h0A, -1, -1);
        checkOutput("below_b_resp", bGotResp, 2'b11);
        readBurst(BASE - 32'h10, 8'd1, 3'd3, 2'b01, 6'h0B, 0);
        checkOutput("below_r_resp0", gotResp(0), 2'b11);
        checkOutput("below_r_resp1", gotResp(1), 2'b11);
        checkOutput("below_r_data1", gotData(1), 64'd0);
        readBurst(BASE, 8'd0, 3'd3, 2'b01, 6'h0C, 0);
        checkOutput("base_unchanged", gotData(0), 64'h0DD00000CAFE0000);

        wData[0] = 64'h13579BDF02468ACE; wData[1] = 64'h1; wStrb[0] = 8'hFF; wStrb[1] = 8'hFF;
        writeBurst(BASE + 32'h7FF8, 8'd1, 3'd3, 2'b01, 6'h0D, -1, -1);
        checkOutput("top_b_resp", bGotResp, 2'b11);
        readBurst(BASE + 32'h7FF8, 8'd1, 3'd3, 2'b01, 6'h0E, 0);
        checkOutput("top_r_resp0", gotResp(0), 2'b00);
        checkOutput("top_r_data0", gotData(0), 64'h13579BDF02468ACE);
        checkOutput("top_r_resp1", gotResp(1), 2'b11);

        for (int i = 0; i < 4; i++) begin wData[i] = 64'(i + 16); wStrb[i] = 8'hFF; end
        writeBurst(BASE + 32'h40, 8'd3, 3'd3, 2'b01, 6'h0F, 2, -1);
        checkOutput("early_last_b_resp", bGotResp, 2'b10);

        writeBurst(BASE + 32'h60, 8'd3, 3'd3, 2'b10, 6'h10, -1, -1);
        checkOutput("wrap_b_resp", bGotResp, 2'b10);
        readBurst(BASE + 32'h60, 8'd1, 3'd3, 2'b10, 6'h11, 0);
        checkOutput("wrap_r_resp", gotResp(0), 2'b10);
        checkOutput("wrap_r_data", gotData(0), 64'd0);

        writeBurst(BASE + 32'h80, 8'd3, 3'd3, 2'b01, 6'h12, -1, 2);
        wData[0] = 64'h0123456789ABCDEF; wStrb[0] = 8'hFF;
        writeBurst(BASE + 32'h88, 8'd0, 3'd3, 2'b01, 6'h13, -1, -1);
        checkOutput("after_wrst_b_resp", bGotResp, 2'b00);
        readBurst(BASE + 32'h88, 8'd0, 3'd3, 2'b01, 6'h14, 0);
        checkOutput("after_wrst_r_data", gotData(0), 64'h0123456789ABCDEF);

        rMode = 3;
        readBurst(BASE + 32'h100, 8'd3, 3'd3, 2'b01, 6'h16, 1);
        rMode = 0;
        readBurst(BASE + 32'h108, 8'd0, 3'd3, 2'b01, 6'h17, 0);
        checkOutput("after_rrst_r_resp", gotResp(0), 2'b00);
        checkOutput("after_rrst_r_data", gotData(0), 64'd1);

        applyStimulus(80);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
